axi_riscv_atop_write_gate: RTL and testbench

- Write-ordering controller placed in front of the AXI RISC-V atomics adapter on the AW channel.
- Counts outstanding regular (non-atomic) write bursts.
- When an atomic AW (atop != 0) arrives, it holds off further AWs until all earlier writes have received their B responses. It then issues the atomic alone.
- It blocks all AWs until the atomic's B response, and its R response when one is required, have completed.

---
 rtl/axi_riscv_atop_write_gate.sv | 137 +++++++++++++
 tb/tb_axi_riscv_atop_write_gate.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_riscv_atop_write_gate.sv
// AW-channel ordering gate: regular writes pass freely up to a limit, an atomic
// waits for all earlier write responses and then runs alone until its responses return.
module axi_riscv_atop_write_gate #(
    parameter int unsigned AXI_ID_WIDTH       = 4,
    parameter int unsigned AXI_MAX_WRITE_TXNS = 8,
    localparam int unsigned CNT_W             = $clog2(AXI_MAX_WRITE_TXNS + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    slv_aw_valid_i,
    output logic                    slv_aw_ready_o,
    input  logic [5:0]              slv_aw_atop_i,
    input  logic [AXI_ID_WIDTH-1:0] slv_aw_id_i,
    output logic                    mst_aw_valid_o,
    input  logic                    mst_aw_ready_i,
    input  logic                    b_valid_i,
    input  logic                    b_ready_i,
    input  logic                    r_valid_i,
    input  logic                    r_ready_i,
    input  logic                    r_last_i,
    input  logic [AXI_ID_WIDTH-1:0] r_id_i,
    output logic                    busy_o,
    output logic [CNT_W-1:0]        cnt_o,
    output logic                    err_o
);

    if (AXI_MAX_WRITE_TXNS < 1) begin : g_bad_max
        $fatal(1, "AXI_MAX_WRITE_TXNS must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        ISSUE,
        WAIT_RESP
    } state_e;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(AXI_MAX_WRITE_TXNS);

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [AXI_ID_WIDTH-1:0] atop_id_q;
    logic                    need_r_q;
    logic                    b_done_q;
    logic                    r_done_q;
    logic                    err_q;

    logic is_atop, cnt_zero, cnt_full;
    logic fwd, aw_hs, b_hs, r_end;
    logic cnt_phase, cnt_inc, cnt_dec, cnt_err;
    logic b_done_n, r_done_n, resp_done, dup_b, drain_drop;

    assign is_atop  = (slv_aw_atop_i != 6'd0);
    assign cnt_zero = (cnt_q == '0);
    assign cnt_full = (cnt_q == MAX_CNT);

    // AW handshake is passed straight through when open; reset forces it shut.
    always_comb begin
        fwd = 1'b0;
        case (state_q)
            IDLE:    fwd = slv_aw_valid_i & ~is_atop & ~cnt_full;
            ISSUE:   fwd = 1'b1;
            default: fwd = 1'b0;
        endcase
        if (rst_i) fwd = 1'b0;
    end

    assign mst_aw_valid_o = fwd & slv_aw_valid_i;
    assign slv_aw_ready_o = fwd & mst_aw_ready_i;

    assign aw_hs = mst_aw_valid_o & mst_aw_ready_i;
    assign b_hs  = b_valid_i & b_ready_i;
    assign r_end = r_valid_i & r_ready_i & r_last_i & (r_id_i == atop_id_q);

    // Only regular bursts are tracked; the atomic's B is consumed in WAIT_RESP.
    assign cnt_phase = (state_q == IDLE) || (state_q == DRAIN);
    assign cnt_inc   = aw_hs & (state_q == IDLE);
    assign cnt_dec   = b_hs & cnt_phase & ~cnt_zero;
    assign cnt_err   = b_hs & cnt_phase & cnt_zero;

    assign b_done_n   = b_done_q | b_hs;
    assign r_done_n   = r_done_q | r_end;
    assign resp_done  = b_done_n & (r_done_n | ~need_r_q);
    assign dup_b      = (state_q == WAIT_RESP) & b_hs & b_done_q;
    assign drain_drop = (state_q == DRAIN) & ~slv_aw_valid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            atop_id_q <= '0;
            need_r_q  <= 1'b0;
            b_done_q  <= 1'b0;
            r_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= cnt_err | dup_b | drain_drop;

            case ({cnt_inc, cnt_dec})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase

            case (state_q)
                IDLE: begin
                    if (slv_aw_valid_i && is_atop) state_q <= DRAIN;
                end
                DRAIN: begin
                    // A withdrawn atomic request is a protocol violation; abandon it.
                    if (!slv_aw_valid_i) state_q <= IDLE;
                    else if (cnt_zero)   state_q <= ISSUE;
                end
                ISSUE: begin
                    if (aw_hs) begin
                        atop_id_q <= slv_aw_id_i;
                        need_r_q  <= slv_aw_atop_i[5];
                        b_done_q  <= 1'b0;
                        r_done_q  <= 1'b0;
                        state_q   <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    b_done_q <= b_done_n;
                    r_done_q <= r_done_n;
                    if (resp_done) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = (state_q != IDLE);
    assign cnt_o  = cnt_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_axi_riscv_atop_write_gate.sv
// Directed plus randomized bench for axi_riscv_atop_write_gate against a
// transaction-level model of outstanding writes and the pending atomic.
module tb_axi_riscv_atop_write_gate;
    localparam int IDW = 4;
    localparam int MAX = 8;
    localparam int CW  = $clog2(MAX + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic           aw_v, aw_r, m_v, m_r;
    logic [5:0]     atop;
    logic [IDW-1:0] aw_id, r_id;
    logic           bv, br, rv, rr, rl;
    logic           busy, err;
    logic [CW-1:0]  cnt;

    always #5 clk = ~clk;

    axi_riscv_atop_write_gate #(.AXI_ID_WIDTH(IDW), .AXI_MAX_WRITE_TXNS(MAX)) dut (
        .clk_i(clk), .rst_i(rst),
        .slv_aw_valid_i(aw_v), .slv_aw_ready_o(aw_r), .slv_aw_atop_i(atop), .slv_aw_id_i(aw_id),
        .mst_aw_valid_o(m_v), .mst_aw_ready_i(m_r),
        .b_valid_i(bv), .b_ready_i(br),
        .r_valid_i(rv), .r_ready_i(rr), .r_last_i(rl), .r_id_i(r_id),
        .busy_o(busy), .cnt_o(cnt), .err_o(err)
    );

    int tests = 0;
    int fails = 0;

    // Model: number of outstanding regular writes, plus the life of one atomic:
    // seen (waiting for earlier writes), cleared (may be sent), in flight (awaiting responses).
    int             outstanding = 0;
    bit             at_seen = 0, at_cleared = 0, at_flight = 0;
    bit             got_b = 0, got_r = 0, want_r = 0, exp_err = 0;
    logic [IDW-1:0] at_id = '0;
    bit             exp_mv, exp_sr, last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_outputs();
        bit open;
        open = (!at_seen && !at_flight && aw_v && atop == 6'd0 && outstanding < MAX)
               || (at_seen && at_cleared);
        exp_mv = !rst && open && aw_v;
        exp_sr = !rst && open && m_r;
    endfunction

    function automatic void model_update();
        bit acc, bdone, rdone;
        acc   = exp_mv && m_r;
        bdone = bv && br;
        rdone = rv && rr && rl && (r_id == at_id);
        last_acc = exp_sr && aw_v;
        if (rst) begin
            outstanding = 0; at_seen = 0; at_cleared = 0; at_flight = 0;
            got_b = 0; got_r = 0; want_r = 0; exp_err = 0; at_id = '0;
            return;
        end
        exp_err = 0;
        if (at_flight) begin
            if (bdone && got_b) exp_err = 1;
            got_b = got_b || bdone;
            got_r = got_r || rdone;
            if (got_b && (got_r || !want_r)) at_flight = 0;
        end else if (at_seen && at_cleared) begin
            if (acc) begin
                at_id = aw_id; want_r = atop[5]; got_b = 0; got_r = 0;
                at_flight = 1; at_seen = 0; at_cleared = 0;
            end
        end else if (at_seen) begin
            if (outstanding == 0) at_cleared = 1;
            if (bdone) begin
                if (outstanding == 0) exp_err = 1;
                else outstanding--;
            end
            if (!aw_v) begin
                exp_err = 1; at_seen = 0; at_cleared = 0;
            end
        end else begin
            if (bdone && outstanding == 0) exp_err = 1;
            outstanding = outstanding + int'(acc) - int'(bdone && outstanding > 0);
            if (aw_v && atop != 6'd0) at_seen = 1;
        end
    endfunction

    // Inputs are changed at the falling edge; outputs are compared 1ns later.
    task automatic step(input string tag);
        #1;
        model_outputs();
        chk({tag, "/mst_valid"}, m_v, exp_mv);
        chk({tag, "/slv_ready"}, aw_r, exp_sr);
        chk({tag, "/cnt"}, cnt, outstanding);
        chk({tag, "/busy"}, busy, at_seen || at_flight);
        chk({tag, "/err"}, err, exp_err);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clr();
        aw_v = 0; atop = '0; aw_id = '0; m_r = 0;
        bv = 0; br = 0; rv = 0; rr = 0; rl = 0; r_id = '0;
    endtask

    task automatic set_aw(input logic [5:0] a, input logic [IDW-1:0] id);
        aw_v = 1; atop = a; aw_id = id; m_r = 1;
    endtask

    task automatic set_r(input logic [IDW-1:0] id);
        rv = 1; rr = 1; rl = 1; r_id = id;
    endtask

    // Present an atomic from an empty gate and walk it into WAIT_RESP.
    task automatic run_atomic(input logic [5:0] a, input logic [IDW-1:0] id);
        clr();
        set_aw(a, id);
        step("at_idle");
        chk("at_drain_busy", busy, 1);
        step("at_drain");
        #1 chk("at_issue_fwd", m_v, 1);
        step("at_issue");
        clr();
    endtask

    initial begin
        rst = 1;
        clr();
        repeat (2) @(posedge clk);
        @(negedge clk);
        step("reset");
        rst = 0;
        chk("reset_cnt", cnt, 0);
        chk("reset_busy", busy, 0);

        // Back-to-back regular writes.
        set_aw(6'd0, 4'd1);
        for (int k = 1; k <= 3; k++) begin
            step("b2b");
            chk($sformatf("b2b_cnt%0d", k), cnt, k);
            chk("b2b_busy", busy, 0);
        end
        repeat (5) step("fill");
        chk("fill_cnt", cnt, 8);

        // Ninth write stalls until a B frees a slot.
        #1 chk("full_slv_ready", aw_r, 0);
        chk("full_mst_valid", m_v, 0);
        step("full");
        bv = 1; br = 1;
        step("full_b");
        chk("full_b_cnt", cnt, 7);
        bv = 0;
        step("full_fwd");
        chk("full_fwd_cnt", cnt, 8);
        aw_v = 0; bv = 1;
        repeat (6) step("drain6");
        chk("down_to_2", cnt, 2);

        // Atomic with two writes outstanding.
        clr();
        set_aw(6'h20, 4'd5);
        step("atA_idle");
        chk("atA_busy", busy, 1);
        bv = 1; br = 1;
        repeat (2) step("atA_drainb");
        chk("atA_cnt0", cnt, 0);
        bv = 0;
        step("atA_drain0");
        #1 chk("atA_issue_fwd", m_v, 1);
        step("atA_issue");
        clr();
        bv = 1; br = 1;
        step("atA_b");
        chk("atA_wait_after_b", busy, 1);
        clr();
        set_r(4'd5);
        step("atA_r");
        chk("atA_done", busy, 0);

        // Atomic store; regular AW waits behind its B.
        run_atomic(6'h10, 4'd2);
        set_aw(6'd0, 4'd1);
        step("st_stall0");
        #1 chk("st_stall_ready", aw_r, 0);
        step("st_stall1");
        bv = 1; br = 1;
        step("st_b");
        chk("st_idle", busy, 0);
        bv = 0;
        step("st_fwd");
        chk("st_fwd_cnt", cnt, 1);
        aw_v = 0; bv = 1;
        step("st_clear");
        chk("st_clear_cnt", cnt, 0);

        // R with a foreign id is ignored; a duplicate B is an error.
        run_atomic(6'h21, 4'd5);
        bv = 1; br = 1; set_r(4'd3);
        step("id3");
        chk("id3_busy", busy, 1);
        clr(); bv = 1; br = 1;
        step("dupb");
        chk("dupb_err", err, 1);
        clr(); set_r(4'd5);
        step("id5");
        chk("id5_done", busy, 0);

        // B and R last in the same cycle end the atomic immediately.
        run_atomic(6'h2a, 4'd5);
        bv = 1; br = 1; set_r(4'd5);
        step("same");
        chk("same_done", busy, 0);

        // Atomic withdrawn during DRAIN.
        clr(); set_aw(6'h01, 4'd7);
        step("drop_idle");
        aw_v = 0;
        step("drop");
        chk("drop_err", err, 1);
        chk("drop_idle_busy", busy, 0);

        // Reset while waiting for responses, then a stray B.
        run_atomic(6'h20, 4'd9);
        rst = 1;
        step("mid_rst");
        rst = 0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", cnt, 0);
        bv = 1; br = 1;
        step("stray_b");
        chk("stray_err", err, 1);
        bv = 0;
        step("stray_after");
        chk("stray_pulse_end", err, 0);
        chk("stray_cnt", cnt, 0);

        // Randomized traffic; AW payload is held until it is accepted.
        clr();
        last_acc = 1;
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (last_acc || !aw_v || $urandom_range(0, 9) == 0) begin
                aw_v  = $urandom_range(0, 1);
                atop  = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
                aw_id = IDW'($urandom);
            end
            m_r  = ($urandom_range(0, 3) != 0);
            bv   = ($urandom_range(0, 2) == 0);
            br   = ($urandom_range(0, 3) != 0);
            rv   = $urandom_range(0, 1);
            rr   = $urandom_range(0, 1);
            rl   = $urandom_range(0, 1);
            r_id = ($urandom_range(0, 2) != 0) ? at_id : IDW'($urandom);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
